// File: rtl/sisc_fetch.sv
// SISC instruction-fetch stage: owns PC and IR, fetches one word per request.
// Define SISC_FETCH_TIMEOUT_EN to abort fetches that wait longer than TMO_CYC cycles.
module sisc_fetch #(
    parameter int          ADDR_W  = 16,
    parameter int          INSTR_W = 32,
    parameter logic [3:0]  HLT_OP  = 4'd15,
    parameter int          TMO_CYC = 15
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               fetch_en,
    input  logic               pc_write,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [ADDR_W-1:0]  pc,
    output logic               ir_valid,
    output logic               halted,
    output logic               fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 req_q, req_d;
    logic                 irv_q, irv_d;
    // set when a branch landed during WAIT, so completion must not increment
    logic                 br_q, br_d;
    logic                 done;

    assign done = (state_q == WAIT) && req_q && imem_valid;

`ifdef SISC_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 tmo;

    assign tmo = (state_q == WAIT) && !done && (cnt_q == CNT_W'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == WAIT && !done) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (tmo) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    logic tmo;
    assign tmo       = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    if (imem_rdata[INSTR_W-1 -: 4] == HLT_OP) begin
                        state_d = HALT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // datapath / output logic
    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        ir_d   = ir_q;
        req_d  = req_q;
        irv_d  = 1'b0;
        br_d   = br_q;
        unique case (state_q)
            IDLE: begin
                br_d = 1'b0;
                if (pc_write) begin
                    pc_d = br_target;
                end
                if (fetch_en) begin
                    req_d  = 1'b1;
                    addr_d = pc_write ? br_target : pc_q;
                end
            end
            WAIT: begin
                if (done) begin
                    ir_d  = imem_rdata;
                    req_d = 1'b0;
                    irv_d = 1'b1;
                    br_d  = 1'b0;
                    if (pc_write) begin
                        pc_d = br_target;
                    end else if (!br_q) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end else begin
                    if (pc_write) begin
                        pc_d = br_target;
                        br_d = 1'b1;
                    end
                    if (tmo) begin
                        req_d = 1'b0;
                    end
                end
            end
            HALT: begin
                req_d = 1'b0;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q   <= '0;
            addr_q <= '0;
            ir_q   <= '0;
            req_q  <= 1'b0;
            irv_q  <= 1'b0;
            br_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            ir_q   <= ir_d;
            req_q  <= req_d;
            irv_q  <= irv_d;
            br_q   <= br_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[INSTR_W-1 -: 4];
    assign mm        = ir_q[INSTR_W-5 -: 4];
    assign pc        = pc_q;
    assign ir_valid  = irv_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_sisc_fetch.sv
// Randomized bench for sisc_fetch against a rule-level fetch model.
// Covers reset, wait states, branches, PC wrap, halt and timeout behaviour.
module tb_sisc_fetch;

    logic        clk;
    logic        rst_f;
    logic        fetch_en;
    logic        pc_write;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] pc;
    logic        ir_valid;
    logic        halted;
    logic        fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_pc;
    logic [31:0] m_ir;

    sisc_fetch dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_en   (fetch_en),
        .pc_write   (pc_write),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .pc         (pc),
        .ir_valid   (ir_valid),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'h0);
        chk({tag, ".ir"}, ir, 32'h0);
        chk({tag, ".op"}, 32'(opcode), 32'h0);
        chk({tag, ".mm"}, 32'(mm), 32'h0);
        chk({tag, ".req"}, 32'(imem_req), 32'h0);
        chk({tag, ".addr"}, 32'(imem_addr), 32'h0);
        chk({tag, ".irv"}, 32'(ir_valid), 32'h0);
        chk({tag, ".hlt"}, 32'(halted), 32'h0);
        chk({tag, ".err"}, 32'(fetch_err), 32'h0);
    endtask

    task automatic do_reset();
        rst_f      = 1'b0;
        fetch_en   = 1'b0;
        pc_write   = 1'b0;
        br_target  = 16'h0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        step();
        step();
        rst_f = 1'b1;
        m_pc  = 16'h0;
        m_ir  = 32'h0;
    endtask

    // Full fetch: optional branch with fetch_en, optional branch at wait
    // cycle wbr (-1 = none), optional branch on the completing cycle.
    task automatic fetch(input logic sbr, input logic [15:0] stgt,
                         input int lat, input int wbr,
                         input logic [15:0] wtgt, input logic cbr,
                         input logic [15:0] ctgt, input logic [31:0] word);
        logic [15:0] exp_addr;
        logic        pend;
        pend      = 1'b0;
        fetch_en  = 1'b1;
        pc_write  = sbr;
        br_target = stgt;
        exp_addr  = sbr ? stgt : m_pc;
        if (sbr) m_pc = stgt;
        step();
        fetch_en = 1'b0;
        pc_write = 1'b0;
        chk("start.req", 32'(imem_req), 32'h1);
        chk("start.addr", 32'(imem_addr), 32'(exp_addr));
        chk("start.irv", 32'(ir_valid), 32'h0);
        for (int w = 0; w < lat; w++) begin
            if (w == wbr) begin
                pc_write  = 1'b1;
                br_target = wtgt;
                m_pc      = wtgt;
                pend      = 1'b1;
            end
            step();
            pc_write = 1'b0;
            chk("wait.req", 32'(imem_req), 32'h1);
            chk("wait.addr", 32'(imem_addr), 32'(exp_addr));
            chk("wait.irv", 32'(ir_valid), 32'h0);
            chk("wait.pc", 32'(pc), 32'(m_pc));
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        pc_write   = cbr;
        br_target  = ctgt;
        step();
        imem_valid = 1'b0;
        pc_write   = 1'b0;
        if (cbr) m_pc = ctgt;
        else if (!pend) m_pc = m_pc + 16'd1;
        m_ir = word;
        chk("done.irv", 32'(ir_valid), 32'h1);
        chk("done.ir", ir, m_ir);
        chk("done.op", 32'(opcode), 32'(m_ir[31:28]));
        chk("done.mm", 32'(mm), 32'(m_ir[27:24]));
        chk("done.pc", 32'(pc), 32'(m_pc));
        chk("done.req", 32'(imem_req), 32'h0);
        chk("done.hlt", 32'(halted), 32'(m_ir[31:28] == 4'd15));
        step();
        chk("after.irv", 32'(ir_valid), 32'h0);
    endtask

    initial begin
        logic [31:0] w;
        int          hi;
        rst_f      = 1'b0;
        fetch_en   = 1'b0;
        pc_write   = 1'b0;
        br_target  = 16'h0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        step();
        chk_reset_vals("rst");
        do_reset();
        chk_reset_vals("rst2");

        // zero-wait first fetch
        fetch(1'b0, 16'h0, 0, -1, 16'h0, 1'b0, 16'h0, 32'h1A00_0000);
        chk("t1.op", 32'(opcode), 32'd1);
        chk("t1.mm", 32'(mm), 32'd10);
        chk("t1.pc", 32'(pc), 32'd1);

        // three wait states
        fetch(1'b0, 16'h0, 3, -1, 16'h0, 1'b0, 16'h0, 32'h2345_6789);
        // branch during WAIT, then fetch from target
        fetch(1'b0, 16'h0, 2, 1, 16'h0040, 1'b0, 16'h0, 32'h3000_0001);
        chk("br.pc", 32'(pc), 32'h0040);
        fetch(1'b0, 16'h0, 0, -1, 16'h0, 1'b0, 16'h0, 32'h4000_0002);
        // branch together with fetch_en
        fetch(1'b1, 16'h1234, 1, -1, 16'h0, 1'b0, 16'h0, 32'h5000_0003);

        // stray strobe in IDLE ignored
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        imem_valid = 1'b0;
        chk("stray.irv", 32'(ir_valid), 32'h0);
        chk("stray.ir", ir, m_ir);
        chk("stray.req", 32'(imem_req), 32'h0);

        // pc_write alone in IDLE, then wrap
        pc_write  = 1'b1;
        br_target = 16'hFFFF;
        step();
        pc_write = 1'b0;
        m_pc     = 16'hFFFF;
        chk("ldpc.pc", 32'(pc), 32'hFFFF);
        chk("ldpc.req", 32'(imem_req), 32'h0);
        fetch(1'b0, 16'h0, 1, -1, 16'h0, 1'b0, 16'h0, 32'h6000_0004);
        chk("wrap.pc", 32'(pc), 32'h0);

        // randomized fetches
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            w[31:28] = 4'($urandom_range(0, 14));
            fetch(1'($urandom_range(0, 3) == 0), 16'($urandom),
                  $urandom_range(0, 4), $urandom_range(0, 5) == 0 ? 0 : -1,
                  16'($urandom), 1'($urandom_range(0, 4) == 0),
                  16'($urandom), w);
        end

        // halt
        fetch(1'b0, 16'h0, 1, -1, 16'h0, 1'b0, 16'h0, 32'hF123_4567);
        fetch_en  = 1'b1;
        pc_write  = 1'b1;
        br_target = 16'h0BAD;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hlt.req", 32'(imem_req), 32'h0);
            chk("hlt.pc", 32'(pc), 32'(m_pc));
            chk("hlt.sticky", 32'(halted), 32'h1);
        end
        fetch_en = 1'b0;
        pc_write = 1'b0;

        // reset mid-WAIT, late strobe ignored
        do_reset();
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk("mid.req", 32'(imem_req), 32'h1);
        step();
        #2;
        rst_f = 1'b0;
        #1;
        chk_reset_vals("async");
        step();
        rst_f      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        imem_valid = 1'b0;
        chk("late.irv", 32'(ir_valid), 32'h0);
        chk("late.ir", ir, 32'h0);
        chk("late.req", 32'(imem_req), 32'h0);

        // unresponsive memory
        fetch(1'b0, 16'h0, 0, -1, 16'h0, 1'b0, 16'h0, 32'h1A00_0000);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) hi++;
            step();
        end
`ifdef SISC_FETCH_TIMEOUT_EN
        chk("tmo.hi", 32'(hi), 32'd15);
        chk("tmo.err", 32'(fetch_err), 32'h1);
        chk("tmo.req", 32'(imem_req), 32'h0);
`else
        chk("hold.hi", 32'(hi), 32'd40);
        chk("hold.err", 32'(fetch_err), 32'h0);
        chk("hold.req", 32'(imem_req), 32'h1);
`endif
        chk("tmo.ir", ir, m_ir);
        chk("tmo.pc", 32'(pc), 32'(m_pc));
        chk("tmo.irv", 32'(ir_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
